cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the two result producers: ALU (RS results) and LSB (load results).
- Buffers each producer's results in its own small FIFO and grants the bus round-robin.
- Drives one registered broadcast (valid, ROB id, value) that feeds the RS and LSB wakeup ports and the ROB.
- Raises per-source almost-full stall signals so upstream issue can hold off before a FIFO overflows.

---
 rtl/cdb_arbiter_pkg.sv | 10 +
 rtl/cdb_src_fifo.sv | 45 ++++
 rtl/cdb_arbiter.sv | 79 +++++++
 tb/tb_cdb_arbiter.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB widths, source encoding and round-robin pick helper
package cdb_arbiter_pkg;
  localparam int CDB_FIFO_DEPTH_BIT = 2;
  localparam int CDB_ROB_ID_BIT = 5;
  localparam int CDB_DATA_W = 32;
  typedef enum logic {CDB_SRC_ALU = 1'b0, CDB_SRC_LSB = 1'b1} cdb_src_e;
  function automatic cdb_src_e rr_pick(input logic alu_req, input logic lsb_req, input cdb_src_e last);
    return (alu_req && (!lsb_req || last == CDB_SRC_LSB)) ? CDB_SRC_ALU : CDB_SRC_LSB;
  endfunction
endpackage

// File: rtl/cdb_src_fifo.sv
// cdb_src_fifo: tag+value result FIFO with count and almost-full stall
module cdb_src_fifo #(
  parameter int DEPTH_BIT = 2,
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         rdy,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         stall
);
  localparam logic [DEPTH_BIT:0] FULL = (DEPTH_BIT+1)'(1 << DEPTH_BIT);
  logic [W-1:0] mem [1 << DEPTH_BIT];
  logic [DEPTH_BIT-1:0] head, tail;
  logic [DEPTH_BIT:0] count;
  logic do_push, do_pop;
  assign do_push = push && count != FULL;
  assign do_pop = pop && !empty;
  assign empty = count == '0;
  assign stall = count >= FULL - 1'b1;
  assign dout = mem[head];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (rdy) begin
      if (clr) begin
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + 1'b1;
        if (do_pop) head <= head + 1'b1;
        count <= count + (DEPTH_BIT+1)'(do_push) - (DEPTH_BIT+1)'(do_pop);
      end
    end
  always_ff @(posedge clk)
    if (rdy && !clr && do_push) mem[tail] <= din;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbitration between ALU and LSB result FIFOs.
// Define CDB_BYPASS_EN to let an empty-FIFO result go straight to the CDB register.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH_BIT = CDB_FIFO_DEPTH_BIT,
  parameter int ROB_ID_BIT = CDB_ROB_ID_BIT,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear_flag,
  input  logic                  alu_valid,
  input  logic [ROB_ID_BIT-1:0] alu_rob_id,
  input  logic [DATA_W-1:0]     alu_val,
  input  logic                  lsb_valid,
  input  logic [ROB_ID_BIT-1:0] lsb_rob_id,
  input  logic [DATA_W-1:0]     lsb_val,
  output logic                  alu_stall,
  output logic                  lsb_stall,
  output logic                  cdb_valid,
  output logic [ROB_ID_BIT-1:0] cdb_rob_id,
  output logic [DATA_W-1:0]     cdb_val
);
  localparam int W = ROB_ID_BIT + DATA_W;
  logic [W-1:0] alu_din, lsb_din, alu_head, lsb_head, win;
  logic alu_empty, lsb_empty, alu_byp, lsb_byp, alu_req, lsb_req, any_req;
  logic alu_pop, lsb_pop, alu_push, lsb_push, clr;
  cdb_src_e last_grant, pick;
  assign alu_din = {alu_rob_id, alu_val};
  assign lsb_din = {lsb_rob_id, lsb_val};
`ifdef CDB_BYPASS_EN
  assign alu_byp = alu_valid && alu_empty;
  assign lsb_byp = lsb_valid && lsb_empty;
`else
  assign alu_byp = 1'b0;
  assign lsb_byp = 1'b0;
`endif
  assign alu_req = !alu_empty || alu_byp;
  assign lsb_req = !lsb_empty || lsb_byp;
  assign any_req = alu_req || lsb_req;
  assign pick = rr_pick(alu_req, lsb_req, last_grant);
  assign alu_pop = any_req && pick == CDB_SRC_ALU;
  assign lsb_pop = any_req && pick == CDB_SRC_LSB;
  // a bypass winner is consumed directly and never enters its FIFO
  assign alu_push = alu_valid && !(alu_byp && alu_pop);
  assign lsb_push = lsb_valid && !(lsb_byp && lsb_pop);
  assign win = pick == CDB_SRC_ALU ? (alu_empty ? alu_din : alu_head) : (lsb_empty ? lsb_din : lsb_head);
  assign clr = clear_flag;
  cdb_src_fifo #(.DEPTH_BIT(FIFO_DEPTH_BIT), .W(W)) u_alu (
    .clk(clk_in), .rst_n(rst_in), .rdy(rdy_in), .clr(clr), .push(alu_push), .pop(alu_pop),
    .din(alu_din), .dout(alu_head), .empty(alu_empty), .stall(alu_stall)
  );
  cdb_src_fifo #(.DEPTH_BIT(FIFO_DEPTH_BIT), .W(W)) u_lsb (
    .clk(clk_in), .rst_n(rst_in), .rdy(rdy_in), .clr(clr), .push(lsb_push), .pop(lsb_pop),
    .din(lsb_din), .dout(lsb_head), .empty(lsb_empty), .stall(lsb_stall)
  );
  always_ff @(posedge clk_in or negedge rst_in)
    if (!rst_in) begin
      cdb_valid <= 1'b0;
      cdb_rob_id <= '0;
      cdb_val <= '0;
      last_grant <= CDB_SRC_LSB;
    end else if (rdy_in) begin
      if (clr) begin
        cdb_valid <= 1'b0;
        cdb_rob_id <= '0;
        cdb_val <= '0;
        last_grant <= CDB_SRC_LSB;
      end else if (any_req) begin
        cdb_valid <= 1'b1;
        {cdb_rob_id, cdb_val} <= win;
        last_grant <= pick;
      end else begin
        cdb_valid <= 1'b0;
      end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed checks of cdb_arbiter in its default (non-bypass) build
module tb_cdb_arbiter;
  logic clk_in = 1'b0, rst_in = 1'b0, rdy_in = 1'b1, clear_flag = 1'b0;
  logic alu_valid = 1'b0, lsb_valid = 1'b0;
  logic [4:0] alu_rob_id = '0, lsb_rob_id = '0;
  logic [31:0] alu_val = '0, lsb_val = '0;
  logic alu_stall, lsb_stall, cdb_valid;
  logic [4:0] cdb_rob_id;
  logic [31:0] cdb_val;
  int checks = 0, errors = 0;
  logic [4:0] ord [6] = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
  cdb_arbiter u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_flag(clear_flag),
    .alu_valid(alu_valid), .alu_rob_id(alu_rob_id), .alu_val(alu_val),
    .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id), .lsb_val(lsb_val),
    .alu_stall(alu_stall), .lsb_stall(lsb_stall),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_val(cdb_val)
  );
  always #5 clk_in = ~clk_in;
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic av, input logic [4:0] at, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lt, input logic [31:0] ld);
    alu_valid = av; alu_rob_id = at; alu_val = ad;
    lsb_valid = lv; lsb_rob_id = lt; lsb_val = ld;
  endtask
  task automatic chk_cdb(input string tag, input logic v, input logic [4:0] id, input logic [31:0] d);
    chk({tag, "_valid"}, cdb_valid, v);
    if (v) begin
      chk({tag, "_rob"}, cdb_rob_id, id);
      chk({tag, "_val"}, cdb_val, d);
    end
  endtask
  initial begin
    #22 rst_in = 1'b1;
    chk_cdb("reset", 1'b0, 5'd0, 32'd0);
    chk("reset_rob", cdb_rob_id, 5'd0);
    chk("reset_val", cdb_val, 32'd0);
    chk("reset_alu_stall", alu_stall, 1'b0);
    chk("reset_lsb_stall", lsb_stall, 1'b0);
    tick();
    // asynchronous reset in the middle of traffic
    drive(1, 5'd3, 32'h11, 0, 0, 0);
    tick();
    drive(1, 5'd4, 32'h22, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_cdb("pre_rst", 1'b1, 5'd3, 32'h11);
    chk("pre_rst_cnt", u_dut.u_alu.count, 3'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("async_rst_valid", cdb_valid, 1'b0);
    chk("async_rst_rob", cdb_rob_id, 5'd0);
    chk("async_rst_alu_cnt", u_dut.u_alu.count, 3'd0);
    chk("async_rst_lsb_cnt", u_dut.u_lsb.count, 3'd0);
    #2 rst_in = 1'b1;
    tick();
    chk_cdb("post_rst1", 1'b0, 0, 0);
    tick();
    chk_cdb("post_rst2", 1'b0, 0, 0);
    // single source latency
    drive(1, 5'd5, 32'hAA, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk_cdb("single_e1", 1'b0, 0, 0);
    tick();
    chk_cdb("single_e2", 1'b1, 5'd5, 32'hAA);
    tick();
    chk_cdb("single_e3", 1'b0, 0, 0);
    chk("single_hold_rob", cdb_rob_id, 5'd5);
    // flush restores ALU priority for the contention run
    clear_flag = 1'b1;
    tick();
    clear_flag = 1'b0;
    chk_cdb("clr0", 1'b0, 0, 0);
    for (int e = 1; e <= 8; e++) begin
      if (e <= 3) drive(1, 5'(e), 32'h100 + e, 1, 5'(8 + e), 32'h108 + e);
      else drive(0, 0, 0, 0, 0, 0);
      tick();
      if (e == 1 || e == 8) chk_cdb($sformatf("rr_e%0d", e), 1'b0, 0, 0);
      else chk_cdb($sformatf("rr_e%0d", e), 1'b1, ord[e-2], 32'h100 + 32'(ord[e-2]));
    end
    // fill LSB to full, then force a dropped push (tag 31)
    for (int e = 1; e <= 15; e++) begin
      if (e <= 7) drive(e <= 6, 5'(16 + e), 32'h300 + 16 + e, 1, 5'(24 + e), 32'h300 + 24 + e);
      else drive(0, 0, 0, 0, 0, 0);
      tick();
      if (e == 1 || e >= 14) chk_cdb($sformatf("full_e%0d", e), 1'b0, 0, 0);
      else if (e % 2 == 0) chk_cdb($sformatf("full_e%0d", e), 1'b1, 5'(16 + e / 2), 32'h300 + 16 + e / 2);
      else chk_cdb($sformatf("full_e%0d", e), 1'b1, 5'(24 + (e - 1) / 2), 32'h300 + 24 + (e - 1) / 2);
      if (e == 3) chk("lsb_stall_cnt2", lsb_stall, 1'b0);
      if (e == 4) begin
        chk("lsb_stall_cnt3", lsb_stall, 1'b1);
        chk("alu_stall_cnt2", alu_stall, 1'b0);
      end
      if (e == 5) chk("alu_stall_cnt3", alu_stall, 1'b1);
      if (e == 6) chk("lsb_cnt_full", u_dut.u_lsb.count, 3'd4);
      if (e == 7) chk("lsb_cnt_after_drop", u_dut.u_lsb.count, 3'd3);
      if (e == 9) chk("lsb_stall_cnt2b", lsb_stall, 1'b0);
    end
    chk("full_hold_rob", cdb_rob_id, 5'd30);
    // flush with two entries queued per source
    drive(1, 5'd7, 32'h407, 1, 5'd12, 32'h40C);
    tick();
    drive(1, 5'd8, 32'h408, 1, 5'd13, 32'h40D);
    tick();
    chk_cdb("flush_pre", 1'b1, 5'd7, 32'h407);
    drive(1, 5'd14, 32'h40E, 1, 5'd15, 32'h40F);
    clear_flag = 1'b1;
    tick();
    clear_flag = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk_cdb("flush_e1", 1'b0, 0, 0);
    chk("flush_rob", cdb_rob_id, 5'd0);
    chk("flush_alu_stall", alu_stall, 1'b0);
    chk("flush_lsb_stall", lsb_stall, 1'b0);
    for (int e = 0; e < 4; e++) begin
      tick();
      chk_cdb($sformatf("flush_idle%0d", e), 1'b0, 0, 0);
    end
    // freeze with queued entries
    drive(1, 5'd20, 32'h514, 1, 5'd22, 32'h516);
    tick();
    drive(1, 5'd21, 32'h515, 0, 0, 0);
    tick();
    chk_cdb("frz_pre", 1'b1, 5'd20, 32'h514);
    drive(1, 5'd29, 32'h51D, 1, 5'd30, 32'h51E);
    rdy_in = 1'b0;
    for (int e = 0; e < 4; e++) begin
      tick();
      chk_cdb($sformatf("frz%0d", e), 1'b1, 5'd20, 32'h514);
      chk($sformatf("frz%0d_alu_cnt", e), u_dut.u_alu.count, 3'd1);
      chk($sformatf("frz%0d_lsb_cnt", e), u_dut.u_lsb.count, 3'd1);
    end
    rdy_in = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    chk_cdb("resume1", 1'b1, 5'd22, 32'h516);
    tick();
    chk_cdb("resume2", 1'b1, 5'd21, 32'h515);
    tick();
    chk_cdb("resume3", 1'b0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
